// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller.
// Holds the ALU op encodings, controller state encodings, the bit
// positions of the {N,Z,C,V} condition flags and the field offsets
// inside the 7-bit ALU_SELECT word {op[2:0], src_a[1:0], src_b[1:0]}.
package alu_issue_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_LSL = 3'd2,
        OP_LSR = 3'd3,
        OP_ASR = 3'd4,
        OP_MUL = 3'd5
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_ABORT = 3'd4
    } state_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned SEL_B_LSB  = 0;
    localparam int unsigned SEL_A_LSB  = 2;
    localparam int unsigned SEL_OP_LSB = 4;
    localparam int unsigned SEL_W      = 7;

    // Opcodes 6 and 7 have no ALU function behind them.
    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_MUL;
    endfunction

endpackage

// File: rtl/alu_strobe_watchdog.sv
// Strobe-wait watchdog for the ALU issue controller.
// Counts cycles spent waiting for SLOW_CLOCK_STRB while in EXEC.
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset
//   clr_i    : synchronous clear (asserted the cycle before EXEC)
//   en_i     : count this cycle (in EXEC with no strobe)
//   expire_o : this is the TMO_MAX-th consecutive cycle without a strobe
module alu_strobe_watchdog #(
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_MAX = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    // Counter holds (EXEC cycle number - 1), so the TMO_MAX-th waiting
    // cycle sees TMO_MAX-1. expire is gated by en_i, so a strobe on that
    // same cycle wins over the timeout.
    localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_MAX - 1);

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller (initiator side of the SAP CPU ALU interface).
// Accepts one decoded instruction over INSTR_VALID/INSTR_READY, drives
// ALU_SELECT/ALU_EN, waits for SLOW_CLOCK_STRB so the ALU commits its
// flags, then presents result and flags to register-file writeback.
//   CLK, RST            : clock, synchronous active-high reset
//   SLOW_CLOCK_STRB     : one-CLK commit strobe shared with the ALU
//   INSTR_*             : decoded instruction handshake and fields
//   ALU_SELECT, ALU_EN  : ALU operand/op select and flag-update enable
//   ALU_OUT, ALU_COND   : ALU result and condition register {N,Z,C,V}
//   WB_*                : one-cycle writeback pulse, address, data, flags
//   ERR                 : one-cycle pulse on illegal op or strobe timeout
//   BUSY                : controller not in IDLE
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_MAX = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SLOW_CLOCK_STRB,
    input  logic              INSTR_VALID,
    output logic              INSTR_READY,
    input  logic [2:0]        INSTR_OP,
    input  logic [1:0]        INSTR_SRC_A,
    input  logic [1:0]        INSTR_SRC_B,
    input  logic [1:0]        INSTR_DST,
    input  logic              INSTR_SETFLAGS,
    output logic [SEL_W-1:0]  ALU_SELECT,
    output logic              ALU_EN,
    input  logic [DATA_W-1:0] ALU_OUT,
    input  logic [3:0]        ALU_COND,
    output logic              WB_VALID,
    output logic [1:0]        WB_ADDR,
    output logic [DATA_W-1:0] WB_DATA,
    output logic [3:0]        WB_FLAGS,
    output logic              ERR,
    output logic              BUSY
);

    state_e             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [1:0]         dst_q;
    logic               setf_q;
    logic               en_q;
    logic               ready_q;
    logic               busy_q;
    logic               wb_valid_q;
    logic [1:0]         wb_addr_q;
    logic [DATA_W-1:0]  wb_data_q;
    logic [3:0]         wb_flags_q;
    logic               err_q;
    logic               wd_expire;

    alu_strobe_watchdog #(
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) u_watchdog (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clr_i    (state_q == ST_SETUP),
        .en_i     ((state_q == ST_EXEC) && !SLOW_CLOCK_STRB),
        .expire_o (wd_expire)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            dst_q      <= '0;
            setf_q     <= 1'b0;
            en_q       <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_flags_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (INSTR_VALID) begin
                        dst_q   <= INSTR_DST;
                        setf_q  <= INSTR_SETFLAGS;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (op_is_legal(INSTR_OP)) begin
                            sel_q   <= {INSTR_OP, INSTR_SRC_A, INSTR_SRC_B};
                            state_q <= ST_SETUP;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_ABORT;
                        end
                    end
                end
                ST_SETUP: begin
                    en_q    <= setf_q;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (SLOW_CLOCK_STRB) begin
                        wb_data_q  <= ALU_OUT;
                        wb_addr_q  <= dst_q;
                        wb_valid_q <= 1'b1;
                        en_q       <= 1'b0;
                        state_q    <= ST_WB;
                    end else if (wd_expire) begin
                        err_q   <= 1'b1;
                        en_q    <= 1'b0;
                        state_q <= ST_ABORT;
                    end
                end
                ST_WB: begin
                    wb_flags_q <= ALU_COND;
                    ready_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                ST_ABORT: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    en_q    <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign INSTR_READY = ready_q;
    assign ALU_SELECT  = sel_q;
    assign ALU_EN      = en_q;
    assign WB_VALID    = wb_valid_q;
    assign WB_ADDR     = wb_addr_q;
    assign WB_DATA     = wb_data_q;
    assign ERR         = err_q;
    assign BUSY        = busy_q;

    // The ALU commits its flags on the strobe edge, so the post-commit
    // value only exists during the WB cycle. It is passed through while
    // WB_VALID is high and held in wb_flags_q afterwards.
    assign WB_FLAGS = (state_q == ST_WB) ? ALU_COND : wb_flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    localparam int DW      = 16;
    localparam int TMO_MAX = 255;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          SLOW_CLOCK_STRB = 1'b0;
    logic          INSTR_VALID = 1'b0;
    logic          INSTR_READY;
    logic [2:0]    INSTR_OP = '0;
    logic [1:0]    INSTR_SRC_A = '0;
    logic [1:0]    INSTR_SRC_B = '0;
    logic [1:0]    INSTR_DST = '0;
    logic          INSTR_SETFLAGS = 1'b0;
    logic [6:0]    ALU_SELECT;
    logic          ALU_EN;
    logic [DW-1:0] ALU_OUT;
    logic [3:0]    ALU_COND;
    logic          WB_VALID;
    logic [1:0]    WB_ADDR;
    logic [DW-1:0] WB_DATA;
    logic [3:0]    WB_FLAGS;
    logic          ERR;
    logic          BUSY;

    alu_issue_ctrl #(.DATA_W(DW), .TMO_W(8), .TMO_MAX(TMO_MAX)) dut (
        .CLK(CLK), .RST(RST), .SLOW_CLOCK_STRB(SLOW_CLOCK_STRB),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
        .INSTR_OP(INSTR_OP), .INSTR_SRC_A(INSTR_SRC_A), .INSTR_SRC_B(INSTR_SRC_B),
        .INSTR_DST(INSTR_DST), .INSTR_SETFLAGS(INSTR_SETFLAGS),
        .ALU_SELECT(ALU_SELECT), .ALU_EN(ALU_EN), .ALU_OUT(ALU_OUT), .ALU_COND(ALU_COND),
        .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .WB_FLAGS(WB_FLAGS),
        .ERR(ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ALU reference: returns {N,Z,C,V, result}.
    function automatic logic [19:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        logic [16:0] s;
        logic [31:0] p;
        logic [15:0] r;
        logic c, v;
        c = 1'b0; v = 1'b0; r = '0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
                        v = (a[15] == b[15]) && (r[15] != a[15]); end
            3'd1: begin r = a - b; c = (a < b);
                        v = (a[15] != b[15]) && (r[15] != a[15]); end
            3'd2: r = a << b[3:0];
            3'd3: r = a >> b[3:0];
            3'd4: r = 16'($signed(a) >>> b[3:0]);
            3'd5: begin p = 32'(a) * 32'(b); r = p[15:0]; end
            default: r = '0;
        endcase
        return {r[15], (r == 16'h0), c, v, r};
    endfunction

    // Behavioural ALU with register file and condition register.
    logic [15:0] regs [4];
    logic [19:0] alu_res;
    logic [3:0]  alu_cond = 4'b0000;
    assign alu_res  = alu_ref(ALU_SELECT[6:4], regs[ALU_SELECT[3:2]], regs[ALU_SELECT[1:0]]);
    assign ALU_OUT  = alu_res[15:0];
    assign ALU_COND = alu_cond;
    always @(posedge CLK) if (SLOW_CLOCK_STRB && ALU_EN) alu_cond <= alu_res[19:16];

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [1:0]  addr;
        logic [15:0] data;
        logic [3:0]  flags;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [3:0]  model_cond = 4'b0000;
    logic [6:0]  last_sel = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: pops one expected event per WB_VALID / ERR pulse.
    always @(negedge CLK) begin
        if (!RST && (WB_VALID || ERR)) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_output: WB_VALID=%0b ERR=%0b with empty queue", WB_VALID, ERR);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_cycle", cyc, e.cyc);
                chk("err_pulse", ERR, e.is_err);
                chk("wb_valid", WB_VALID, !e.is_err);
                if (!e.is_err) begin
                    chk("wb_addr", WB_ADDR, e.addr);
                    chk("wb_data", WB_DATA, e.data);
                    chk("wb_flags", WB_FLAGS, e.flags);
                end
            end
        end
    end

    // Called at a negedge. d = EXEC cycle carrying the strobe (0 = none).
    task automatic issue(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] dst, input logic sf, input int d, input bit noise);
        exp_t        e;
        int          c0;
        int          n;
        bit          en_seen;
        logic [19:0] r;
        INSTR_OP = op; INSTR_SRC_A = a; INSTR_SRC_B = b; INSTR_DST = dst;
        INSTR_SETFLAGS = sf; INSTR_VALID = 1'b1;
        for (int i = 0; i < 600 && !INSTR_READY; i++) @(negedge CLK);
        chk("ready_wait", INSTR_READY, 1'b1);
        if (!INSTR_READY) begin INSTR_VALID = 1'b0; return; end
        c0 = cyc + 1;
        r  = alu_ref(op, regs[a], regs[b]);
        e.addr = dst; e.data = r[15:0];
        if (op > 3'd5) begin
            e.is_err = 1'b1; e.cyc = c0; e.flags = '0;
        end else if (d >= 1 && d <= TMO_MAX) begin
            if (sf) model_cond = r[19:16];
            e.is_err = 1'b0; e.cyc = c0 + d + 1; e.flags = model_cond;
        end else begin
            e.is_err = 1'b1; e.cyc = c0 + TMO_MAX + 1; e.flags = '0;
        end
        exp_q.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
        INSTR_VALID = 1'b0;
        if (op > 3'd5) begin
            chk("illegal_sel_held", ALU_SELECT, last_sel);
            chk("illegal_alu_en", ALU_EN, 1'b0);
            @(negedge CLK);
            chk("illegal_ready_after", INSTR_READY, 1'b1);
            return;
        end
        last_sel = {op, a, b};
        chk("setup_select", ALU_SELECT, last_sel);
        chk("setup_alu_en", ALU_EN, 1'b0);
        SLOW_CLOCK_STRB = noise;
        en_seen = 1'b0;
        n = (d >= 1 && d <= TMO_MAX) ? d : TMO_MAX;
        for (int i = 1; i <= n; i++) begin
            @(negedge CLK);
            en_seen |= ALU_EN;
            SLOW_CLOCK_STRB = (i == d);
        end
        @(negedge CLK);
        SLOW_CLOCK_STRB = 1'b0;
        chk("exec_alu_en", en_seen, sf);
        chk("post_exec_alu_en", ALU_EN, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4; i++) regs[i] = '0;
        repeat (3) @(negedge CLK);
        chk("rst_ready", INSTR_READY, 1'b1);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_alu_sel", ALU_SELECT, 7'd0);
        chk("rst_alu_en", ALU_EN, 1'b0);
        chk("rst_wb_valid", WB_VALID, 1'b0);
        chk("rst_wb_addr", WB_ADDR, 2'd0);
        chk("rst_wb_data", WB_DATA, 16'd0);
        chk("rst_wb_flags", WB_FLAGS, 4'd0);
        chk("rst_err", ERR, 1'b0);
        RST = 1'b0;
        @(negedge CLK);

        regs[0] = 16'h0003; regs[1] = 16'h0004;
        issue(3'd0, 2'd0, 2'd1, 2'd2, 1'b1, 2, 1'b0);
        regs[0] = 16'h1234; regs[1] = 16'h1234;
        issue(3'd1, 2'd0, 2'd1, 2'd3, 1'b1, 1, 1'b1);
        regs[0] = 16'h8000;
        issue(3'd0, 2'd0, 2'd0, 2'd1, 1'b0, 3, 1'b1);
        issue(3'd6, 2'd1, 2'd2, 2'd0, 1'b1, 1, 1'b0);
        issue(3'd7, 2'd3, 2'd3, 2'd3, 1'b0, 1, 1'b0);
        regs[2] = 16'hF00F; regs[3] = 16'h0004;
        issue(3'd2, 2'd2, 2'd3, 2'd0, 1'b1, 0, 1'b0);
        issue(3'd4, 2'd2, 2'd3, 2'd1, 1'b1, TMO_MAX, 1'b0);

        // Reset during EXEC.
        INSTR_OP = 3'd5; INSTR_SRC_A = 2'd2; INSTR_SRC_B = 2'd3; INSTR_DST = 2'd2;
        INSTR_SETFLAGS = 1'b1; INSTR_VALID = 1'b1;
        for (int i = 0; i < 20 && !INSTR_READY; i++) @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        INSTR_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        chk("exec_alu_en_before_rst", ALU_EN, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_alu_en", ALU_EN, 1'b0);
        chk("midrst_busy", BUSY, 1'b0);
        chk("midrst_ready", INSTR_READY, 1'b1);
        chk("midrst_wb_valid", WB_VALID, 1'b0);
        chk("midrst_sel", ALU_SELECT, 7'd0);
        RST = 1'b0;
        last_sel = '0;
        @(negedge CLK);
        regs[0] = 16'h0101; regs[1] = 16'h0010;
        issue(3'd5, 2'd0, 2'd1, 2'd3, 1'b1, 2, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [2:0] op;
            for (int i = 0; i < 4; i++) regs[i] = 16'($urandom);
            if ($urandom_range(0, 4) == 0) regs[1] = regs[0];
            op = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
            issue(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom_range(1, 6), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge CLK);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
